btn_conditioner: RTL
====================

// Module: btn_conditioner
// PURPOSE
//  Input front-end for the calculator: takes raw board buttons and switches and
//  delivers clean, synchronous signals to the accumulator/ALU datapath.
//  - 2-flop synchroniser on every input.
//  - Per-button debounce FSM.
//  - One-cycle press strobe per button, so a held button updates the accumulator once.
//  - Switches are synchronised only.
//  - Button index map: [0]=btnc [1]=btnl [2]=btnu [3]=btnr [4]=btnd.
// PARAMETERS
//  NBTN        5          number of buttons
//  SW_W        16         switch bus width
//  DB_CYCLES   500000     debounce length in clk cycles; >=2; counter width $clog2(DB_CYCLES)
//  RPT_DELAY   25000000   cycles from press strobe to first auto-repeat strobe (macro only)
//  RPT_PERIOD  5000000    cycles between subsequent auto-repeat strobes (macro only)
//  RPT_MASK    5'b00000   per-button auto-repeat enable (macro only)
// PORTS
//  clk        in   1      system clock; all logic on posedge
//  rst_n      in   1      reset, asynchronous assert, active-low
//  btn_raw    in   NBTN   raw asynchronous buttons, 1 = pressed
//  sw_raw     in   SW_W   raw asynchronous switches
//  btn_level  out  NBTN   debounced button level
//  btn_pulse  out  NBTN   1-cycle strobe on debounced press (and on auto-repeat)
//  sw_sync    out  SW_W   synchronised switches
// BEHAVIOUR
//  Reset
//   - rst_n=0 immediately clears: sync flops, FSMs (->IDLE), counters,
//     btn_level, btn_pulse, sw_sync.
//  Synchroniser and outputs
//   - s1 <= raw, s2 <= s1. s2 is the "synced" value.
//   - sw_sync = s2 (latency 2).
//   - All outputs are registered.
//  Per-button FSM (cnt = debounce counter)
//   - IDLE:     synced=1 -> CHK_PRESS, cnt<=0.
//   - CHK_PRESS: synced=0 -> IDLE.
//                cnt==DB_CYCLES-1 -> PRESSED; btn_level<=1; btn_pulse<=1 for one cycle.
//                otherwise cnt++.
//   - PRESSED:  synced=0 -> CHK_REL, cnt<=0.
//   - CHK_REL:  synced=1 -> PRESSED, with no strobe.
//                cnt==DB_CYCLES-1 -> IDLE; btn_level<=0; no release strobe.
//                otherwise cnt++.
//  Latency
//   - Raw high first sampled at edge 1 (clean input): btn_level=1 and btn_pulse=1
//     after edge DB_CYCLES+3.
//   - Release is symmetric: btn_level=0 after edge DB_CYCLES+3.
//  Boundary conditions
//   - Glitch: synced high for <=DB_CYCLES samples is rejected. No strobe, level unchanged.
//   - Bounce during release that returns to 1 keeps btn_level=1 and issues no second strobe.
//   - Buttons are fully independent; simultaneous presses give same-cycle strobes.
//   - btn_pulse is never high in two consecutive cycles, except with
//     auto-repeat when RPT_PERIOD=1.
//   - Reset mid-debounce discards progress.
//   - A button held through reset release is debounced from scratch and strobes once.
// CONFIGURATION
//  Macro BTN_CONDITIONER_AUTOREPEAT_EN
//   Defined:
//    - Each button with RPT_MASK[i]=1 has a repeat counter, cleared on entry to PRESSED.
//    - Initial strobe at edge E. Extra strobes at E+RPT_DELAY, then every
//      RPT_PERIOD cycles while the FSM stays in PRESSED.
//    - Leaving PRESSED clears the counter; re-entry from CHK_REL restarts RPT_DELAY
//      and issues no strobe.
//   Undefined:
//    - No repeat counters are built; RPT_* parameters are ignored.
//    - Exactly one strobe per debounced press.
// TESTING  (DB_CYCLES=4, RPT_DELAY=10, RPT_PERIOD=5 in bench)
//  1 btn_raw[4] 0->1 held 30 cycles, then 0
//    -> btn_pulse[4] high exactly one cycle, after edge 7;
//       btn_level[4]=1 from edge 7;
//       btn_level[4]=0 seven edges after release; no release strobe.
//  2 btn_raw[0] toggles 1/0 every 2 cycles for 12 cycles, then held 1
//    -> exactly one btn_pulse[0]; btn_level[0] rises once.
//  3 btn_raw[2] high for 3 cycles only
//    -> btn_pulse and btn_level stay 0 throughout.
//  4 btn_raw[1] and btn_raw[3] rise on the same cycle
//    -> btn_pulse=5'b01010 on one cycle; other bits 0.
//  5 rst_n=0 mid CHK_PRESS with the button held; release rst_n
//    -> all outputs 0 during reset; one strobe 7 edges after rst_n rises.
//       sw_raw=16'hA5C3 -> sw_sync=16'hA5C3 two edges later.
//  6 Macro defined, RPT_MASK=5'b10000, btn_raw[4] held; strobe at edge E
//    -> further strobes at E+10, E+15, E+20, ...
//       Same test with macro undefined -> only the strobe at E.

Source files
------------

// File: rtl/btn_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | btn_conditioner: synchronises buttons/switches, debounces each button and   |
// | emits a one-cycle press strobe. Auto-repeat: BTN_CONDITIONER_AUTOREPEAT_EN.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module btn_conditioner #(
  parameter int              NBTN       = 5,
  parameter int              SW_W       = 16,
  parameter int              DB_CYCLES  = 500000,
  parameter int              RPT_DELAY  = 25000000,
  parameter int              RPT_PERIOD = 5000000,
  parameter logic [NBTN-1:0] RPT_MASK   = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NBTN-1:0] btn_raw_i,
  input  logic [SW_W-1:0] sw_raw_i,
  output logic [NBTN-1:0] btn_level_o,
  output logic [NBTN-1:0] btn_pulse_o,
  output logic [SW_W-1:0] sw_sync_o
);

  localparam int            CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHK_PRESS = 2'd1,
    PRESSED   = 2'd2,
    CHK_REL   = 2'd3
  } state_e;

  logic [NBTN-1:0] btn_s1_q, btn_s2_q;
  logic [SW_W-1:0] sw_s1_q, sw_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      btn_s1_q <= btn_raw_i;
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= sw_raw_i;
      sw_s2_q  <= sw_s1_q;
    end
  end

  assign sw_sync_o = sw_s2_q;

`ifndef BTN_CONDITIONER_AUTOREPEAT_EN
  logic w_unused_rpt_cfg;
  assign w_unused_rpt_cfg = (RPT_DELAY == 0) ^ (RPT_PERIOD == 0) ^ (^RPT_MASK);
`endif

  genvar i;
  generate
    for (i = 0; i < NBTN; i++) begin : g_btn
      state_e        state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          level_q, level_d;
      logic          press_d;
      logic          pulse_q;
      logic          rpt_fire;
      logic          synced;

      assign synced = btn_s2_q[i];

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        case (state_q)
          IDLE: begin
            if (synced) begin
              state_d = CHK_PRESS;
              cnt_d   = '0;
            end
          end
          CHK_PRESS: begin
            if (!synced) begin
              state_d = IDLE;
            end else if (cnt_q == CNT_MAX) begin
              state_d = PRESSED;
              level_d = 1'b1;
              press_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          PRESSED: begin
            if (!synced) begin
              state_d = CHK_REL;
              cnt_d   = '0;
            end
          end
          CHK_REL: begin
            // A bounce back to 1 resumes the held state silently.
            if (synced) begin
              state_d = PRESSED;
            end else if (cnt_q == CNT_MAX) begin
              state_d = IDLE;
              level_d = 1'b0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          level_q <= 1'b0;
          pulse_q <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          level_q <= level_d;
          pulse_q <= press_d | rpt_fire;
        end
      end

`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
      if (RPT_MASK[i]) begin : g_rpt
        localparam int            RMAX    = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
        localparam int            RW      = (RMAX > 1) ? $clog2(RMAX) : 1;
        localparam logic [RW-1:0] DLY_MAX = RW'(RPT_DELAY - 1);
        localparam logic [RW-1:0] PER_MAX = RW'(RPT_PERIOD - 1);

        logic [RW-1:0] rcnt_q, rcnt_d;
        logic          rep_q, rep_d;

        // rep_q selects the period once the initial delay has elapsed.
        always_comb begin
          rcnt_d   = rcnt_q + 1'b1;
          rep_d    = rep_q;
          rpt_fire = 1'b0;
          if ((state_q != PRESSED) || !synced) begin
            rcnt_d = '0;
            rep_d  = 1'b0;
          end else if (rcnt_q == (rep_q ? PER_MAX : DLY_MAX)) begin
            rpt_fire = 1'b1;
            rcnt_d   = '0;
            rep_d    = 1'b1;
          end
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            rcnt_q <= '0;
            rep_q  <= 1'b0;
          end else begin
            rcnt_q <= rcnt_d;
            rep_q  <= rep_d;
          end
        end
      end else begin : g_no_rpt
        assign rpt_fire = 1'b0;
      end
`else
      assign rpt_fire = 1'b0;
`endif

      assign btn_level_o[i] = level_q;
      assign btn_pulse_o[i] = pulse_q;
    end
  endgenerate

endmodule
`default_nettype wire
